dmem_arbiter: RTL and testbench

//  Shares the single-port byte-addressed data memory between two requesters:

---
 rtl/dmem_arbiter.sv | 118 +++++++++++
 tb/tb_dmem_arbiter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: MEM stage (p0, fixed priority) vs loader (p1).
// Starvation guard, bounds check, registered load responses, err pulse.
module dmem_arbiter #(
  parameter int MEM_BYTES = 128,
  parameter int MAX_WAIT  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_wdata,
  output logic        p0_gnt,
  output logic        p0_stall,
  output logic        p0_rvalid,
  output logic [31:0] p0_rdata,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wdata,
  output logic        p1_gnt,
  output logic        p1_rvalid,
  output logic [31:0] p1_rdata,
  output logic        err,
  output logic [31:0] mem_address,
  output logic [31:0] mem_writeData,
  output logic        mem_memRead,
  output logic        mem_memWrite,
  input  logic [31:0] mem_memData
);

  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam logic [WW-1:0] MAXW = WW'(MAX_WAIT);
  localparam logic [31:0] TOP = 32'(MEM_BYTES - 4);

  logic [WW-1:0] wait_cnt;
  logic          starve;
  logic          any_gnt;
  logic          w_we;
  logic [31:0]   w_addr;
  logic [31:0]   w_wdata;
  logic          in_range;
  logic          ld_ok;

  assign starve = (wait_cnt >= MAXW);

  // Grants are forced low while reset is held.
  assign p1_gnt   = reset & p1_req & (~p0_req | starve);
  assign p0_gnt   = reset & p0_req & ~p1_gnt;
  assign p0_stall = p0_req & ~p0_gnt;
  assign any_gnt  = p0_gnt | p1_gnt;

  always_comb begin
    w_we    = 1'b0;
    w_addr  = '0;
    w_wdata = '0;
    unique case (1'b1)
      p1_gnt: begin
        w_we    = p1_we;
        w_addr  = p1_addr;
        w_wdata = p1_wdata;
      end
      p0_gnt: begin
        w_we    = p0_we;
        w_addr  = p0_addr;
        w_wdata = p0_wdata;
      end
      default: ;
    endcase
  end

  // Full 32-bit compare: high addresses never wrap into range.
  assign in_range = (w_addr <= TOP);

  always_comb begin
    mem_address   = '0;
    mem_writeData = '0;
    mem_memRead   = 1'b0;
    mem_memWrite  = 1'b0;
    if (any_gnt && in_range) begin
      mem_address   = w_addr;
      mem_writeData = w_wdata;
      mem_memWrite  = w_we;
      mem_memRead   = ~w_we;
    end
  end

  assign ld_ok = in_range;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt <= '0;
    end else if (!p1_req || p1_gnt) begin
      wait_cnt <= '0;
    end else if (wait_cnt < MAXW) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      p0_rvalid <= 1'b0;
      p1_rvalid <= 1'b0;
      p0_rdata  <= '0;
      p1_rdata  <= '0;
      err       <= 1'b0;
    end else begin
      p0_rvalid <= p0_gnt & ~p0_we;
      p1_rvalid <= p1_gnt & ~p1_we;
      err       <= any_gnt & ~in_range;
      if (p0_gnt && !p0_we)
        p0_rdata <= ld_ok ? mem_memData : '0;
      if (p1_gnt && !p1_we)
        p1_rdata <= ld_ok ? mem_memData : '0;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small word memory model.
// Inputs change 1ns after posedge; outputs are checked on negedge.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        p0_req, p0_we;
  logic [31:0] p0_addr, p0_wdata;
  logic        p0_gnt, p0_stall, p0_rvalid;
  logic [31:0] p0_rdata;
  logic        p1_req, p1_we;
  logic [31:0] p1_addr, p1_wdata;
  logic        p1_gnt, p1_rvalid;
  logic [31:0] p1_rdata;
  logic        err;
  logic [31:0] mem_address, mem_writeData, mem_memData;
  logic        mem_memRead, mem_memWrite;

  logic [31:0] mem [0:31];
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.MEM_BYTES(128), .MAX_WAIT(4)) dut (
    .clk(clk), .reset(reset),
    .p0_req(p0_req), .p0_we(p0_we),
    .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt), .p0_stall(p0_stall),
    .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we),
    .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(p1_gnt),
    .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
    .err(err),
    .mem_address(mem_address),
    .mem_writeData(mem_writeData),
    .mem_memRead(mem_memRead),
    .mem_memWrite(mem_memWrite),
    .mem_memData(mem_memData)
  );

  assign mem_memData = mem[mem_address[6:2]];

  always @(posedge clk)
    if (mem_memWrite) mem[mem_address[6:2]] <= mem_writeData;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    p0_req = 0; p0_we = 0; p0_addr = 0; p0_wdata = 0;
    p1_req = 0; p1_we = 0; p1_addr = 0; p1_wdata = 0;
  endtask

  task automatic drv0(input logic we, input logic [31:0] a,
                      input logic [31:0] d);
    p0_req = 1; p0_we = we; p0_addr = a; p0_wdata = d;
  endtask

  task automatic drv1(input logic we, input logic [31:0] a,
                      input logic [31:0] d);
    p1_req = 1; p1_we = we; p1_addr = a; p1_wdata = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'h1000_0000 + i;
    idle();
    reset = 0;
    // grants held low while in reset
    p0_req = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_gnt0", {31'b0, p0_gnt}, 0);
    chk("rst_rd", {31'b0, mem_memRead}, 0);
    step();
    reset = 1;
    idle();
    @(negedge clk);
    chk("t1_rv0", {31'b0, p0_rvalid}, 0);
    chk("t1_rv1", {31'b0, p1_rvalid}, 0);
    chk("t1_err", {31'b0, err}, 0);
    chk("t1_rw", {30'b0, mem_memRead, mem_memWrite}, 0);
    chk("t1_addr", mem_address, 0);

    // store then load on p0
    step();
    drv0(1, 32'h10, 32'hDEADBEEF);
    @(negedge clk);
    chk("t2_sgnt", {31'b0, p0_gnt}, 1);
    chk("t2_swr", {31'b0, mem_memWrite}, 1);
    chk("t2_sadr", mem_address, 32'h10);
    step();
    drv0(0, 32'h10, 0);
    @(negedge clk);
    chk("t2_lgnt", {31'b0, p0_gnt}, 1);
    chk("t2_lrd", {31'b0, mem_memRead}, 1);
    chk("t2_nrv", {31'b0, p0_rvalid}, 0);
    step();
    idle();
    @(negedge clk);
    chk("t2_rv", {31'b0, p0_rvalid}, 1);
    chk("t2_rd", p0_rdata, 32'hDEADBEEF);
    step();
    @(negedge clk);
    chk("t2_rv_lo", {31'b0, p0_rvalid}, 0);
    chk("t2_hold", p0_rdata, 32'hDEADBEEF);

    // contention: p1 forced through after 4 losses
    step();
    drv0(0, 32'h0, 0);
    drv1(0, 32'h10, 0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk($sformatf("t3_g0_%0d", i), {31'b0, p0_gnt},
          (i == 4) ? 0 : 1);
      chk($sformatf("t3_g1_%0d", i), {31'b0, p1_gnt},
          (i == 4) ? 1 : 0);
      chk($sformatf("t3_st_%0d", i), {31'b0, p0_stall},
          (i == 4) ? 1 : 0);
      if (i == 5) begin
        chk("t3_p1rv", {31'b0, p1_rvalid}, 1);
        chk("t3_p1rd", p1_rdata, 32'hDEADBEEF);
      end
      step();
    end
    idle();

    // bounds on p1
    step();
    drv1(0, 32'h7D, 0);
    @(negedge clk);
    chk("t4_gnt", {31'b0, p1_gnt}, 1);
    chk("t4_rd", {31'b0, mem_memRead}, 0);
    step();
    drv1(0, 32'h7C, 0);
    @(negedge clk);
    chk("t4_err", {31'b0, err}, 1);
    chk("t4_rv", {31'b0, p1_rvalid}, 1);
    chk("t4_rdat", p1_rdata, 0);
    chk("t4_rd7c", {31'b0, mem_memRead}, 1);
    step();
    idle();
    @(negedge clk);
    chk("t4_err7c", {31'b0, err}, 0);
    chk("t4_rv7c", {31'b0, p1_rvalid}, 1);
    chk("t4_dat7c", p1_rdata, 32'h1000_001F);

    // store at top of address space must not wrap
    step();
    drv0(1, 32'hFFFF_FFFC, 32'h5555_AAAA);
    @(negedge clk);
    chk("t4_wgnt", {31'b0, p0_gnt}, 1);
    chk("t4_wr", {31'b0, mem_memWrite}, 0);
    step();
    idle();
    @(negedge clk);
    chk("t4_werr", {31'b0, err}, 1);
    chk("t4_wrv", {31'b0, p0_rvalid}, 0);
    chk("t4_m31", mem[31], 32'h1000_001F);

    // reset drops in-flight load
    step();
    drv0(0, 32'h10, 0);
    @(negedge clk);
    chk("t5_gnt", {31'b0, p0_gnt}, 1);
    #2;
    reset = 0;
    #1;
    chk("t5_rgnt", {31'b0, p0_gnt}, 0);
    step();
    reset = 1;
    idle();
    @(negedge clk);
    chk("t5_rv", {31'b0, p0_rvalid}, 0);
    chk("t5_rd", p0_rdata, 0);
    chk("t5_mem", mem[4], 32'hDEADBEEF);

    // overlap: p0 response alongside p1 store grant
    step();
    drv0(0, 32'h0, 0);
    @(negedge clk);
    chk("t6_g0", {31'b0, p0_gnt}, 1);
    step();
    idle();
    drv1(1, 32'h4, 32'h1234_5678);
    @(negedge clk);
    chk("t6_g1", {31'b0, p1_gnt}, 1);
    chk("t6_wr", {31'b0, mem_memWrite}, 1);
    chk("t6_rv0", {31'b0, p0_rvalid}, 1);
    chk("t6_rd0", p0_rdata, 32'h1000_0000);
    chk("t6_rv1", {31'b0, p1_rvalid}, 0);
    step();
    idle();
    @(negedge clk);
    chk("t6_rv0b", {31'b0, p0_rvalid}, 0);
    chk("t6_rv1b", {31'b0, p1_rvalid}, 0);
    chk("t6_mem", mem[1], 32'h1234_5678);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
